drp_responder_regfile: RTL and testbench

- DRP responder (slave) that answers DRP read/write transactions from an XADC-style DRP initiator.
- Exposes a small bank of filter configuration registers plus one read-only status word to the fabric.
- Sits between the DRP initiator logic and the filter datapath, so software-style register access uses the same handshake the team already drives into the XADC.

---
 rtl/drp_responder_regfile.sv | 221 ++++++++++++++++++++++
 tb/tb_drp_responder_regfile.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/drp_responder_regfile.sv
`default_nettype none
// ============================================================================
// Module   : drp_responder_regfile
// Brief    : DRP responder exposing RW filter config registers plus a
//            read-only status word. Define DRP_ERR_CNT_EN to add the
//            saturating ERRCNT protocol-error register.
// Revision : 1.0 - initial release
// ============================================================================
module drp_responder_regfile #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 7,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 7'h40,
    parameter int                NUM_REGS  = 8,
    parameter int                LATENCY   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       den,
    input  logic                       dwe,
    input  logic [ADDR_W-1:0]          daddr,
    input  logic [DATA_W-1:0]          di,
    output logic [DATA_W-1:0]          do_out,
    output logic                       drdy,
    input  logic [DATA_W-1:0]          sts_in,
    output logic [NUM_REGS*DATA_W-1:0] cfg_q,
    output logic                       wr_stb,
    output logic [3:0]                 wr_idx
);

    localparam logic [3:0]        c_lat_m1 = 4'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] c_nregs  = ADDR_W'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [3:0]                  r_cnt;
    logic [3:0]                  w_cnt_nxt;
    logic                        w_go_ack;

    logic [ADDR_W-1:0]           r_addr;
    logic                        r_we;
    logic [DATA_W-1:0]           r_wdata;

    logic [ADDR_W-1:0]           w_req_addr;
    logic                        w_req_we;
    logic [DATA_W-1:0]           w_req_wdata;
    logic [ADDR_W-1:0]           w_off;
    logic                        w_above;
    logic                        w_is_cfg;
    logic                        w_is_sts;
    logic [3:0]                  w_idx;
    logic [DATA_W-1:0]           w_rdata;
    logic                        w_cfg_wr;

    logic [NUM_REGS*DATA_W-1:0]  r_cfg;
    logic [DATA_W-1:0]           r_do;
    logic                        r_drdy;
    logic                        r_wr_stb;
    logic [3:0]                  r_wr_idx;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_go_ack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (den) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_ACK;
                        w_go_ack    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_lat_m1;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_ACK;
                    w_go_ack    = 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch; only loaded from IDLE so busy-time den cannot disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (den && (r_state == S_IDLE)) begin
            r_addr  <= daddr;
            r_we    <= dwe;
            r_wdata <= di;
        end
    end

    // With LATENCY=1 the ack is decided in IDLE, before the latch is loaded
    assign w_req_addr  = (r_state == S_IDLE) ? daddr : r_addr;
    assign w_req_we    = (r_state == S_IDLE) ? dwe   : r_we;
    assign w_req_wdata = (r_state == S_IDLE) ? di    : r_wdata;

    // ------------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------------
    assign w_off    = w_req_addr - BASE_ADDR;
    assign w_above  = (w_req_addr >= BASE_ADDR);
    assign w_is_cfg = w_above && (w_off < c_nregs);
    assign w_is_sts = w_above && (w_off == c_nregs);
    assign w_idx    = w_off[3:0];
    assign w_cfg_wr = w_go_ack && w_req_we && w_is_cfg;

`ifdef DRP_ERR_CNT_EN
    logic       w_is_err;
    logic       w_oow;
    logic       w_busy_den;
    logic [1:0] w_inc;
    logic [8:0] w_sum;
    logic [7:0] r_errcnt;

    assign w_is_err   = w_above && (w_off == (c_nregs + ADDR_W'(1)));
    assign w_oow      = !(w_is_cfg || w_is_sts || w_is_err);
    assign w_busy_den = den && (r_state != S_IDLE);
    assign w_inc      = {1'b0, w_busy_den} + {1'b0, (w_go_ack && w_oow)};
    assign w_sum      = {1'b0, r_errcnt} + {7'd0, w_inc};

    // Clear on write takes priority over any increment in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errcnt <= 8'd0;
        end else if (w_go_ack && w_req_we && w_is_err) begin
            r_errcnt <= 8'd0;
        end else if (w_sum[8]) begin
            r_errcnt <= 8'hFF;
        end else begin
            r_errcnt <= w_sum[7:0];
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_off == ADDR_W'(i)) begin
                    w_rdata = r_cfg[i*DATA_W +: DATA_W];
                end
            end
        end else if (w_is_sts) begin
            w_rdata = sts_in;
        end
`ifdef DRP_ERR_CNT_EN
        else if (w_is_err) begin
            w_rdata = {{(DATA_W-8){1'b0}}, r_errcnt};
        end
`endif
    end

    // ------------------------------------------------------------------------
    // Register bank and response outputs, all updated on the drdy-raising edge
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= '0;
        end else if (w_cfg_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_idx == 4'(i)) begin
                    r_cfg[i*DATA_W +: DATA_W] <= w_req_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drdy   <= 1'b0;
            r_do     <= '0;
            r_wr_stb <= 1'b0;
            r_wr_idx <= 4'd0;
        end else begin
            r_drdy   <= w_go_ack;
            r_do     <= (w_go_ack && !w_req_we) ? w_rdata : '0;
            r_wr_stb <= w_cfg_wr;
            r_wr_idx <= w_cfg_wr ? w_idx : 4'd0;
        end
    end

    assign do_out = r_do;
    assign drdy   = r_drdy;
    assign wr_stb = r_wr_stb;
    assign wr_idx = r_wr_idx;
    assign cfg_q  = r_cfg;

endmodule
`default_nettype wire

// File: tb/tb_drp_responder_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_drp_responder_regfile
// Brief    : Self-checking bench: transaction-level model for the LATENCY=2
//            instance plus literal checks on a LATENCY=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drp_responder_regfile;

    localparam int LAT  = 2;
    localparam int NR   = 8;
    localparam int BASE = 64;
`ifdef DRP_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         den = 1'b0, dwe = 1'b0;
    logic [6:0]   daddr = '0;
    logic [15:0]  di = '0, sts_in = '0;
    logic [15:0]  do_out;
    logic         drdy, wr_stb;
    logic [3:0]   wr_idx;
    logic [127:0] cfg_q;

    logic         den1 = 1'b0, dwe1 = 1'b0;
    logic [6:0]   daddr1 = '0;
    logic [15:0]  di1 = '0, sts_in1 = '0;
    logic [15:0]  do_out1;
    logic         drdy1, wr_stb1;
    logic [3:0]   wr_idx1;
    logic [127:0] cfg_q1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    drp_responder_regfile u_dut (
        .clk(clk), .rst_n(rst_n), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
        .do_out(do_out), .drdy(drdy), .sts_in(sts_in), .cfg_q(cfg_q),
        .wr_stb(wr_stb), .wr_idx(wr_idx)
    );

    drp_responder_regfile #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .den(den1), .dwe(dwe1), .daddr(daddr1), .di(di1),
        .do_out(do_out1), .drdy(drdy1), .sts_in(sts_in1), .cfg_q(cfg_q1),
        .wr_stb(wr_stb1), .wr_idx(wr_idx1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Transaction model: one pending request, response LAT cycles after den
    // ------------------------------------------------------------------------
    int          e = 0, resp_e = 0, inc = 0, m_err = 0;
    bit          pend = 0, clr = 0;
    logic [6:0]  m_addr;
    logic        m_we;
    logic [15:0] m_di;
    logic [15:0] m_cfg [NR];
    logic        exp_drdy = 0, exp_stb = 0;
    logic [15:0] exp_do = '0;
    logic [3:0]  exp_idx = '0;

    task automatic respond();
        int off;
        off = int'(m_addr) - BASE;
        exp_drdy = 1'b1;
        if (off >= 0 && off < NR) begin
            if (m_we) begin
                m_cfg[off] = m_di;
                exp_stb = 1'b1;
                exp_idx = 4'(off);
            end else begin
                exp_do = m_cfg[off];
            end
        end else if (off == NR) begin
            if (!m_we) exp_do = sts_in;
        end else if (ERR_EN && off == NR + 1) begin
            if (m_we) clr = 1;
            else      exp_do = 16'(m_err);
        end else begin
            inc++;
        end
    endtask

    function automatic logic [127:0] model_cfgq();
        logic [127:0] v;
        for (int i = 0; i < NR; i++) v[i*16 +: 16] = m_cfg[i];
        return v;
    endfunction

    always @(posedge clk) begin
        e++;
        exp_drdy = 0; exp_do = '0; exp_stb = 0; exp_idx = '0;
        if (!rst_n) begin
            pend = 0; m_err = 0;
            for (int i = 0; i < NR; i++) m_cfg[i] = '0;
        end else begin
            inc = 0; clr = 0;
            if (pend) begin
                if (den) inc++;
                if (e == resp_e) respond();
                if (e == resp_e + 1) pend = 0;
            end else if (den) begin
                pend = 1; resp_e = e + LAT - 1;
                m_addr = daddr; m_we = dwe; m_di = di;
                if (e == resp_e) respond();
            end
            if (clr) m_err = 0;
            else     m_err = (m_err + inc > 255) ? 255 : m_err + inc;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_drdy", 128'(drdy), 128'(0));
            chk("rst_do", 128'(do_out), 128'(0));
            chk("rst_stb", 128'(wr_stb), 128'(0));
            chk("rst_idx", 128'(wr_idx), 128'(0));
            chk("rst_cfg", cfg_q, 128'(0));
        end else begin
            chk("drdy", 128'(drdy), 128'(exp_drdy));
            chk("do_out", 128'(do_out), 128'(exp_do));
            chk("wr_stb", 128'(wr_stb), 128'(exp_stb));
            if (exp_stb) chk("wr_idx", 128'(wr_idx), 128'(exp_idx));
            chk("cfg_q", cfg_q, model_cfgq());
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic xact(input logic we, input logic [6:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic stb,
                        output logic [3:0] idx, output int lat);
        den = 1'b1; dwe = we; daddr = a; di = d;
        tick();
        den = 1'b0; dwe = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (drdy) break;
            lat++;
        end
        rd = do_out; stb = wr_stb; idx = wr_idx;
        tick();
    endtask

    task automatic x1(input logic we, input logic [6:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic rdy);
        den1 = 1'b1; dwe1 = we; daddr1 = a; di1 = d;
        tick();
        den1 = 1'b0; dwe1 = 1'b0;
        @(negedge clk);
        rd = do_out1; rdy = drdy1;
        tick();
    endtask

    initial begin
        logic [15:0]  rd;
        logic         stb, rdy;
        logic [3:0]   idx;
        int           lat, cnt;
        logic [127:0] snap;

        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_cfg", cfg_q, 128'(0));
        rst_n = 1'b1;
        tick();

        xact(1'b1, 7'h40, 16'h1234, rd, stb, idx, lat);
        chk("w40_lat", 128'(lat), 128'(2));
        chk("w40_stb", 128'(stb), 128'(1));
        chk("w40_idx", 128'(idx), 128'(0));
        chk("w40_cfg", 128'(cfg_q[15:0]), 128'(16'h1234));
        xact(1'b0, 7'h40, 16'h0000, rd, stb, idx, lat);
        chk("r40_data", 128'(rd), 128'(16'h1234));

        sts_in = 16'hA5A5;
        xact(1'b0, 7'h48, 16'h0000, rd, stb, idx, lat);
        chk("rsts_data", 128'(rd), 128'(16'hA5A5));
        snap = cfg_q;
        xact(1'b1, 7'h48, 16'hFFFF, rd, stb, idx, lat);
        chk("wsts_stb", 128'(stb), 128'(0));
        chk("wsts_cfg", cfg_q, snap);

        xact(1'b0, 7'h3F, 16'h0000, rd, stb, idx, lat);
        chk("r3f_data", 128'(rd), 128'(0));
        chk("r3f_lat", 128'(lat), 128'(2));
        xact(1'b0, 7'h7F, 16'h0000, rd, stb, idx, lat);
        chk("r7f_data", 128'(rd), 128'(0));
        xact(1'b0, 7'h49, 16'h0000, rd, stb, idx, lat);
        chk("errcnt_2", 128'(rd), 128'(ERR_EN ? 2 : 0));

        // Second den while busy must be ignored
        den = 1'b1; dwe = 1'b1; daddr = 7'h41; di = 16'h0001;
        tick();
        di = 16'h0002;
        tick();
        den = 1'b0; dwe = 1'b0;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (drdy) cnt++;
        end
        tick();
        chk("busy_drdy_cnt", 128'(cnt), 128'(1));
        chk("busy_reg1", 128'(cfg_q[31:16]), 128'(16'h0001));
        xact(1'b0, 7'h49, 16'h0000, rd, stb, idx, lat);
        chk("errcnt_3", 128'(rd), 128'(ERR_EN ? 3 : 0));

        // Reset aborts an in-flight write
        den = 1'b1; dwe = 1'b1; daddr = 7'h47; di = 16'hBEEF;
        tick();
        den = 1'b0; dwe = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("abort_reg7", 128'(cfg_q[127:112]), 128'(0));
        chk("abort_cfg", cfg_q, 128'(0));

        // LATENCY=1 instance: back-to-back requests two cycles apart
        for (int k = 0; k < 7; k++) begin
            den1 = (k == 0 || k == 2 || k == 4);
            dwe1 = den1;
            daddr1 = 7'(64 + k / 2);
            di1 = 16'(k + 1);
            @(negedge clk);
            chk($sformatf("l1_drdy_c%0d", k), 128'(drdy1),
                128'(k == 1 || k == 3 || k == 5));
            tick();
        end
        den1 = 1'b0; dwe1 = 1'b0;
        tick();
        chk("l1_cfg", 128'(cfg_q1[47:0]), 128'(48'h0005_0003_0001));

        // 600 cycles of continuous den: every other one lands in ACK
        den1 = 1'b1; dwe1 = 1'b0; daddr1 = 7'h40;
        repeat (600) tick();
        den1 = 1'b0;
        repeat (2) tick();
        x1(1'b0, 7'h49, 16'h0000, rd, rdy);
        chk("l1_sat_rdy", 128'(rdy), 128'(1));
        chk("l1_sat_val", 128'(rd), 128'(ERR_EN ? 255 : 0));
        x1(1'b1, 7'h49, 16'h1234, rd, rdy);
        chk("l1_clr_rdy", 128'(rdy), 128'(1));
        x1(1'b0, 7'h49, 16'h0000, rd, rdy);
        chk("l1_clr_val", 128'(rd), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
